// File: rtl/st_bus_packer_if.sv
// Handshake and bus signals for st_bus_packer. The stream side carries narrow
// beats in, and the bus side carries packed words out.
// slave  : the packer's view.
// master : the view of whatever drives the stream and takes the bus words.
interface st_bus_packer_if #(
    parameter int ST         = 8,
    parameter int ST_PER_BUS = 512
);
    logic [ST-1:0]         st_data;
    logic                  st_valid;
    logic                  st_sop;
    logic                  st_eop;
    logic                  st_ready;
    logic                  bus_ready;
    logic [ST_PER_BUS-1:0] bus_data;
    logic                  bus_en;
    logic                  bus_last;
    logic                  pkt_err;
    logic [15:0]           pkt_cnt;

    modport master (
        output st_data, st_valid, st_sop, st_eop, bus_ready,
        input  st_ready, bus_data, bus_en, bus_last, pkt_err, pkt_cnt
    );

    modport slave (
        input  st_data, st_valid, st_sop, st_eop, bus_ready,
        output st_ready, bus_data, bus_en, bus_last, pkt_err, pkt_cnt
    );
endinterface

// File: rtl/st_bus_packer.sv
// Packs ST-bit stream beats into ST_PER_BUS-bit bus words through two
// ping-pong buffers. The fill side closes a word when the word is full or
// when the packet ends. The drain side emits one word per strobe. After the
// last word of a packet, the drain side holds the bus idle for GAP_CYCLES
// cycles.
//
// Fill FSM
//   state  | meaning
//   F_IDLE | between packets; only a beat with st_sop starts a packet
//   F_PKT  | inside a packet; beats are packed until st_eop
// Drain FSM
//   state  | meaning
//   D_OUT  | emit the read-side buffer when it is valid and bus_ready is high
//   D_GAP  | mandatory idle after a bus_last word; r_gap counts down to 0
module st_bus_packer #(
    parameter int ST         = 8,
    parameter int ST_PER_BUS = 512,
    parameter int GAP_CYCLES = 25
) (
    input  logic           clk_bus,
    input  logic           rst_n,
    st_bus_packer_if.slave bif
);
    localparam int NUM_ST_PER_BUS = ST_PER_BUS / ST;
    localparam int CW = (NUM_ST_PER_BUS > 1) ? $clog2(NUM_ST_PER_BUS) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(NUM_ST_PER_BUS - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic {F_IDLE, F_PKT} fill_t;
    typedef enum logic {D_OUT, D_GAP} drain_t;

    fill_t                 r_fill, w_fill_nxt;
    drain_t                r_drain, w_drain_nxt;
    logic [ST_PER_BUS-1:0] r_buf [2];
    logic [1:0]            r_valid;
    logic [1:0]            r_last;
    logic                  r_wr_sel;
    logic                  r_rd_sel;
    logic [CW-1:0]         r_lane;
    logic [GW-1:0]         r_gap;
    logic                  r_rst_done;
    logic [ST_PER_BUS-1:0] r_bus_data;
    logic                  r_bus_en;
    logic                  r_bus_last;
    logic                  r_pkt_err;
    logic [15:0]           r_pkt_cnt;

    logic w_st_ready;
    logic w_accept;
    logic w_write;
    logic w_close;
    logic w_err;
    logic w_emit;

    // st_ready depends only on flops. r_rst_done holds st_ready low while
    // reset is asserted, even though both buffers read as free then.
    assign w_st_ready   = r_rst_done & ~r_valid[r_wr_sel];

    assign bif.st_ready = w_st_ready;
    assign bif.bus_data = r_bus_data;
    assign bif.bus_en   = r_bus_en;
    assign bif.bus_last = r_bus_last;
    assign bif.pkt_err  = r_pkt_err;
    assign bif.pkt_cnt  = r_pkt_cnt;

    // Fill FSM decode: accept, drop or pack the beat, and flag framing errors.
    always_comb begin
        w_accept   = bif.st_valid & w_st_ready;
        w_write    = 1'b0;
        w_err      = 1'b0;
        w_fill_nxt = r_fill;
        case (r_fill)
            F_IDLE: begin
                if (w_accept) begin
                    if (bif.st_sop) begin
                        w_write = 1'b1;
                        if (!bif.st_eop) w_fill_nxt = F_PKT;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            F_PKT: begin
                if (w_accept) begin
                    w_write = 1'b1;
                    if (bif.st_sop) w_err = 1'b1;
                    if (bif.st_eop) w_fill_nxt = F_IDLE;
                end
            end
            default: w_fill_nxt = F_IDLE;
        endcase
        w_close = w_write & (bif.st_eop | (r_lane == LAST_LANE));
    end

    // Drain FSM decode: emit when a word is waiting; after a last word, go to GAP.
    always_comb begin
        w_drain_nxt = r_drain;
        w_emit      = 1'b0;
        case (r_drain)
            D_OUT: begin
                if (r_valid[r_rd_sel] && bif.bus_ready) begin
                    w_emit = 1'b1;
                    if (r_last[r_rd_sel] && (GAP_CYCLES > 0)) w_drain_nxt = D_GAP;
                end
            end
            D_GAP: begin
                if (r_gap == '0) w_drain_nxt = D_OUT;
            end
            default: w_drain_nxt = D_OUT;
        endcase
    end

    // State registers for both FSMs, plus the flag that enables st_ready once reset is released.
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            r_fill     <= F_IDLE;
            r_drain    <= D_OUT;
            r_rst_done <= 1'b0;
        end else begin
            r_fill     <= w_fill_nxt;
            r_drain    <= w_drain_nxt;
            r_rst_done <= 1'b1;
        end
    end

    // Fill datapath: write the beat into its lane and step the lane and buffer pointers.
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            r_buf[0]  <= '0;
            r_buf[1]  <= '0;
            r_lane    <= '0;
            r_wr_sel  <= 1'b0;
            r_pkt_err <= 1'b0;
        end else begin
            r_pkt_err <= w_err;
            if (w_write) begin
                // Lane 0 rewrites the whole word, so the unused upper lanes of a short word are zero.
                if (r_lane == '0)
                    r_buf[r_wr_sel] <= ST_PER_BUS'(bif.st_data);
                else
                    r_buf[r_wr_sel][int'(r_lane)*ST +: ST] <= bif.st_data;
            end
            if (w_close) begin
                r_lane   <= '0;
                r_wr_sel <= ~r_wr_sel;
            end else if (w_write) begin
                r_lane   <= r_lane + 1'b1;
            end
        end
    end

    // Buffer valid and last flags. Fill only sets flags on a free buffer and drain
    // only clears flags on a full one, so the two writes never hit the same index.
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 2'b00;
            r_last  <= 2'b00;
        end else begin
            if (w_emit) r_valid[r_rd_sel] <= 1'b0;
            if (w_close) begin
                r_valid[r_wr_sel] <= 1'b1;
                r_last[r_wr_sel]  <= bif.st_eop;
            end
        end
    end

    // Drain datapath: register the bus outputs, the gap down-counter and the packet count.
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_data <= '0;
            r_bus_en   <= 1'b0;
            r_bus_last <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_pkt_cnt  <= 16'd0;
            r_gap      <= '0;
        end else begin
            r_bus_en   <= w_emit;
            r_bus_last <= w_emit & r_last[r_rd_sel];
            if (w_emit) begin
                r_bus_data <= r_buf[r_rd_sel];
                r_rd_sel   <= ~r_rd_sel;
                if (r_last[r_rd_sel]) r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
            if (w_emit && r_last[r_rd_sel])
                r_gap <= GAP_LOAD;
            else if ((r_drain == D_GAP) && (r_gap != '0))
                r_gap <= r_gap - 1'b1;
        end
    end
endmodule

// File: doc/st_bus_packer.md
ST_BUS_PACKER -- requirements
Module: st_bus_packer

Interface
REQ-001 SHALL have parameter ST, default 8, meaning width of one stream beat in bits.
REQ-002 SHALL have parameter ST_PER_BUS, default 512, meaning bus word width in bits; must be an integer multiple of ST.
REQ-003 SHALL have parameter GAP_CYCLES, default 25, meaning minimum idle clk_bus cycles on the bus after a word flagged bus_last.
REQ-004 SHALL derive localparam NUM_ST_PER_BUS = ST_PER_BUS/ST (beats per bus word).
REQ-005 SHALL have one clock; reset is asynchronous and active-low: clk_bus  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 st_data  in  ST  stream beat payload.
REQ-008 st_valid  in  1  beat present.
REQ-009 st_sop  in  1  first beat of packet.
REQ-010 st_eop  in  1  last beat of packet.
REQ-011 st_ready  out  1  beat accepted when st_valid && st_ready.
REQ-012 bus_ready  in  1  downstream can take a word this cycle.
REQ-013 bus_data  out  ST_PER_BUS  packed word, valid when bus_en.
REQ-014 bus_en  out  1  one-cycle word strobe.
REQ-015 bus_last  out  1  word is final word of its packet; qualified by bus_en.
REQ-016 pkt_err  out  1  one-cycle framing-error pulse.
REQ-017 pkt_cnt  out  16  completed packets emitted, wraps 0xFFFF->0.

Function
REQ-018 SHALL hold two word buffers (ping-pong), each with valid and last flags; fill side writes buffer wr_sel, drain side reads rd_sel, both toggle after use.
REQ-019 SHALL drive st_ready = !valid[wr_sel], from registered state only.
REQ-020 SHALL place beat k (0-based within word) at bus_data[k*ST +: ST]; unused upper lanes of a short word SHALL be zero.
REQ-021 SHALL close a word (set valid) on the accepted beat with in-word count NUM_ST_PER_BUS-1 or with st_eop; last flag = st_eop of that beat; in-word count returns to 0.
REQ-022 Fill FSM states IDLE, PKT: IDLE + accepted beat with st_sop -> PKT (unless st_eop, stays IDLE); PKT + accepted st_eop -> IDLE.
REQ-023 sop and eop on same beat SHALL produce one word with bus_last=1.
REQ-024 Accepted beat without st_sop in IDLE SHALL be dropped, pkt_err pulsed next cycle, state unchanged.
REQ-025 Accepted st_sop in PKT SHALL pulse pkt_err; beat packed as continuation.
REQ-026 Drain FSM states OUT, GAP: in OUT, if valid[rd_sel] && bus_ready, register bus_data, bus_en=1, bus_last=last flag, clear valid[rd_sel], toggle rd_sel; else bus_en=0, bus_data holds.
REQ-027 After emitting a word with last=1, drain SHALL enter GAP for exactly GAP_CYCLES cycles with bus_en=0, then OUT; pkt_cnt increments on that emit; fill side unaffected by GAP.
REQ-028 Latency: completing beat accepted in cycle c, bus_ready high -> bus_en high in cycle c+2.
REQ-029 Sustained throughput with bus_ready=1 and no GAP SHALL be one beat per cycle (st_ready never drops).
REQ-030 A buffer freed by drain in cycle c SHALL be writable from cycle c+1; no same-buffer read and write in one cycle.
REQ-031 bus_ready low SHALL stall drain indefinitely without data loss; st_ready falls when both buffers valid.

Reset
REQ-032 On rst_n low, asynchronously: st_ready=0, bus_en=0, bus_last=0, bus_data=0, pkt_err=0, pkt_cnt=0, buffers invalid and zero, wr_sel=rd_sel=0, both FSMs to IDLE/OUT, counters 0.
REQ-033 Reset mid-packet SHALL discard partial and pending words; st_ready=1 first cycle after release.

Verification (ST=8, ST_PER_BUS=512, GAP_CYCLES=25)
REQ-034 128-beat packet, st_data=k&0xFF, bus_ready=1 -> two bus_en pulses, word0 byte k = k, word1 byte k = 64+k, bus_last only on word1, pkt_cnt=1.
REQ-035 70-beat packet -> word1 bits[47:0]=beats 64..69, bits[511:48]=0, bus_last=1.
REQ-036 bus_ready=0, continuous 200-beat packet -> st_ready low after beat 128, no bus_en; raise bus_ready -> words resume in order, all 200 beats delivered, 4 words.
REQ-037 Two back-to-back single-beat packets (sop&eop) -> two words, each bus_last=1, second bus_en exactly 26 cycles after first, pkt_cnt=2.
REQ-038 Beat without sop while idle -> pkt_err pulse, no bus_en; sop mid-packet -> pkt_err pulse, packet completes normally.
REQ-039 rst_n low after 40 beats of a packet -> all outputs 0 immediately, no bus_en after release until new sop packet.
